// File: rtl/egress_frame_buffer_pkg.sv
// Shared types and constants for the egress frame buffer: stored word
// format, FSM state encodings and the lane-count helper.
package egress_pkg;

  localparam int LANE_BYTES = 4;
  localparam int WORD_BYTES = 16;

  // One stored RAM entry: 128-bit data plus end-of-frame marker and byte count.
  typedef struct packed {
    logic [127:0] data;
    logic         last;
    logic [4:0]   bytes;
  } egress_word_t;

  typedef enum logic [1:0] {WR_IDLE, WR_RECV, WR_DISCARD} wr_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_e;

  // Lanes to emit for a word: 4 for interior words, ceil(bytes/4) for the last.
  function automatic logic [2:0] lane_count(input egress_word_t w);
    logic [5:0] b;
    b = {1'b0, w.bytes} + 6'(LANE_BYTES - 1);
    return w.last ? b[4:2] : 3'(WORD_BYTES / LANE_BYTES);
  endfunction

endpackage

// File: rtl/egress_frame_buffer_if.sv
// Fabric-side frame bus (with the forward_en credit) and 32-bit transmit lane bus.
interface egress_frame_if;
  logic         frame_valid;
  logic         frame_last;
  logic [4:0]   frame_bytes;
  logic [127:0] frame_data;
  logic         frame_abort;
  logic         forward_en;

  modport master (output frame_valid, frame_last, frame_bytes, frame_data, frame_abort,
                  input  forward_en);
  modport slave  (input  frame_valid, frame_last, frame_bytes, frame_data, frame_abort,
                  output forward_en);
endinterface

interface egress_tx_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [2:0]  tx_bytes;
  logic        tx_last;

  modport master (output tx_valid, tx_data, tx_bytes, tx_last, input tx_ready);
  modport slave  (input  tx_valid, tx_data, tx_bytes, tx_last, output tx_ready);
endinterface

// File: rtl/egress_frame_buffer_word_ram.sv
// Simple dual-port word store: one write port, one registered read port.
// The read register holds its value until the next read, so it doubles as
// the current-word latch for the transmit side.
module egress_word_ram
  import egress_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  egress_word_t wdata,
  input  logic         re,
  input  logic [AW-1:0] raddr,
  output egress_word_t rdata
);

  egress_word_t mem [DEPTH];
  egress_word_t rdata_q;

  // Write port and registered read port; the array carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/egress_frame_buffer.sv
// Egress frame buffer: stores fabric frames with commit/rollback, releases
// only complete frames to the transmit side and serializes them into lanes.
module egress_frame_buffer
  import egress_pkg::*;
#(
  parameter int DEPTH_WORDS     = 256,
  parameter int MAX_FRAME_WORDS = 97,
  parameter int ADDR_BITS       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  egress_frame_if.slave     fab,
  egress_tx_if.master       tx,
  output logic [15:0]       drop_count,
  output logic [15:0]       frame_count
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_FRAME_WORDS);
  localparam logic [7:0]    MAX_W   = 8'(MAX_FRAME_WORDS);

  wr_state_e     wr_state_q, wr_state_d;
  rd_state_e     rd_state_q, rd_state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rd_ptr_inc, used, free;
  logic [7:0]    wr_cnt_q, wr_cnt_d;
  logic [15:0]   drop_count_q, drop_count_d, frame_count_q, frame_count_d;
  logic          forward_en_q, forward_en_d;
  logic          tx_valid_q, tx_valid_d;
  logic [1:0]    lane_q, lane_d;
  logic          store, drop, rd_en, accept, final_lane, word_end;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [2:0]    lanes;
  logic [4:0]    tail_bytes;
  logic [31:0]   lane_data [4];
  egress_word_t  wr_word, rd_word;

  assign wr_word = '{data: fab.frame_data, last: fab.frame_last, bytes: fab.frame_bytes};

  egress_word_ram #(.DEPTH(DEPTH_WORDS), .AW(ADDR_BITS)) u_ram (
    .clk   (clk),
    .we    (store),
    .waddr (wr_ptr_q[ADDR_BITS-1:0]),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  // Write FSM: speculative stores, commit on last word, rollback on abort/oversize.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_cnt_d    = wr_cnt_q;
    store       = 1'b0;
    drop        = 1'b0;
    case (wr_state_q)
      WR_IDLE: begin
        if (fab.frame_valid) begin
          if (forward_en_q) begin
            store      = 1'b1;
            wr_cnt_d   = 8'd1;
            wr_state_d = fab.frame_last ? WR_IDLE : WR_RECV;
          end else begin
            // Fabric started without credit: refuse the whole frame.
            drop       = 1'b1;
            wr_state_d = fab.frame_last ? WR_IDLE : WR_DISCARD;
          end
        end
      end
      WR_RECV: begin
        if (fab.frame_abort) begin
          wr_ptr_d   = wr_commit_q;
          drop       = 1'b1;
          wr_state_d = WR_IDLE;
        end else if (fab.frame_valid) begin
          if (wr_cnt_q >= MAX_W) begin
            wr_ptr_d   = wr_commit_q;
            drop       = 1'b1;
            wr_state_d = fab.frame_last ? WR_IDLE : WR_DISCARD;
          end else begin
            store    = 1'b1;
            wr_cnt_d = wr_cnt_q + 8'd1;
            if (fab.frame_last) wr_state_d = WR_IDLE;
          end
        end
      end
      WR_DISCARD: begin
        if (fab.frame_valid && fab.frame_last) wr_state_d = WR_IDLE;
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (store) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
      if (fab.frame_last) wr_commit_d = wr_ptr_q + PW'(1);
    end
    drop_count_d = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
  end

  // Space credit from next-cycle pointers: room for a maximum frame and no frame open.
  always_comb begin
    used         = wr_ptr_d - rd_ptr_d;
    free         = DEPTH_P - used;
    forward_en_d = (free >= MAX_P) && (wr_state_d == WR_IDLE);
  end

  // Lane slices of the current word, first byte in the top bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_data[gi] = rd_word.data[127 - 32*gi -: 32];
  end

  assign lanes      = lane_count(rd_word);
  assign final_lane = ({1'b0, lane_q} == lanes - 3'd1);
  assign word_end   = final_lane && rd_word.last;
  assign tail_bytes = rd_word.bytes - {lanes - 3'd1, 2'b00};
  assign accept     = tx_valid_q && tx.tx_ready;
  assign rd_ptr_inc = rd_ptr_q + PW'(1);

  // Read FSM: fetch committed words and step through their lanes; the next
  // word is read on the accepting cycle so consecutive words have no gap.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_ptr_d      = rd_ptr_q;
    lane_d        = lane_q;
    tx_valid_d    = tx_valid_q;
    frame_count_d = frame_count_q;
    rd_en         = 1'b0;
    rd_addr       = (rd_state_q == RD_IDLE) ? rd_ptr_q[ADDR_BITS-1:0] : rd_ptr_inc[ADDR_BITS-1:0];
    case (rd_state_q)
      RD_IDLE: begin
        if (rd_ptr_q != wr_commit_q) begin
          rd_en      = 1'b1;
          rd_state_d = RD_FETCH;
        end
      end
      RD_FETCH: begin
        // Word now sits in the RAM read register; start at lane 0.
        lane_d     = 2'd0;
        tx_valid_d = 1'b1;
        rd_state_d = RD_SEND;
      end
      RD_SEND: begin
        if (accept) begin
          if (final_lane) begin
            rd_ptr_d = rd_ptr_inc;
            lane_d   = 2'd0;
            if (rd_word.last) frame_count_d = frame_count_q + 16'd1;
            if (rd_ptr_inc != wr_commit_q) begin
              rd_en = 1'b1;
            end else begin
              tx_valid_d = 1'b0;
              rd_state_d = RD_IDLE;
            end
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // State and pointer registers; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q    <= WR_IDLE;
      rd_state_q    <= RD_IDLE;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      wr_cnt_q      <= '0;
      drop_count_q  <= '0;
      frame_count_q <= '0;
      forward_en_q  <= 1'b0;
      tx_valid_q    <= 1'b0;
      lane_q        <= '0;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_cnt_q      <= wr_cnt_d;
      drop_count_q  <= drop_count_d;
      frame_count_q <= frame_count_d;
      forward_en_q  <= forward_en_d;
      tx_valid_q    <= tx_valid_d;
      lane_q        <= lane_d;
    end
  end

  // Lane outputs are forced to zero whenever no lane is offered.
  assign tx.tx_valid    = tx_valid_q;
  assign tx.tx_data     = tx_valid_q ? lane_data[lane_q] : 32'd0;
  assign tx.tx_bytes    = tx_valid_q ? (word_end ? tail_bytes[2:0] : 3'd4) : 3'd0;
  assign tx.tx_last     = tx_valid_q && word_end;
  assign fab.forward_en = forward_en_q;
  assign drop_count     = drop_count_q;
  assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_egress_frame_buffer.sv
// Directed bench for egress_frame_buffer: a byte-stream model produces the
// expected lane sequence; a negedge monitor compares accepted lanes and stall hold.
module tb_egress_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] drop_count, frame_count;

  always #5 clk = ~clk;

  egress_frame_if fab_if ();
  egress_tx_if    tx_if ();

  egress_frame_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fab         (fab_if),
    .tx          (tx_if),
    .drop_count  (drop_count),
    .frame_count (frame_count)
  );

  int          checks_total  = 0;
  int          checks_passed = 0;
  int          lanes_seen    = 0;
  int          frames_seen   = 0;
  bit          prev_stall    = 1'b0;
  logic [35:0] held, mon_cur, mon_exp;
  logic [35:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] bval(input int id, input int i);
    return 8'((id * 37 + i * 7 + 3) & 255);
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected lanes of a frame: 4-byte groups of the byte stream, tail holds the rest.
  task automatic push_lanes(input int nbytes, input int id);
    int nl;
    nl = (nbytes + 3) / 4;
    for (int j = 0; j < nl; j++) begin
      logic [31:0] d;
      int nb;
      d  = '0;
      nb = (j == nl - 1) ? nbytes - 4 * j : 4;
      for (int k = 0; k < nb; k++) d[31 - 8*k -: 8] = bval(id, 4 * j + k);
      exp_q.push_back({(j == nl - 1), 3'(nb), d});
    end
  endtask

  task automatic wait_fwd();
    int n;
    n = 0;
    while (!fab_if.forward_en && n < 3000) begin
      cycle();
      n++;
    end
    chk("forward_en_wait", 64'(fab_if.forward_en), 64'd1);
  endtask

  // Drive one frame word per cycle; abort_at marks the word carrying frame_abort.
  task automatic send_frame(input int nbytes, input int id, input int abort_at, input bit expect_ok);
    int nw;
    nw = (nbytes + 15) / 16;
    wait_fwd();
    if (expect_ok) push_lanes(nbytes, id);
    for (int w = 0; w < nw; w++) begin
      logic [127:0] d;
      d = '0;
      for (int i = 0; i < 16; i++)
        if (16 * w + i < nbytes) d[127 - 8*i -: 8] = bval(id, 16 * w + i);
      fab_if.frame_valid = 1'b1;
      fab_if.frame_data  = d;
      fab_if.frame_last  = (w == nw - 1);
      fab_if.frame_bytes = (w == nw - 1) ? 5'(nbytes - 16 * w) : 5'd16;
      fab_if.frame_abort = (w == abort_at);
      cycle();
      if (w == abort_at) break;
    end
    fab_if.frame_valid = 1'b0;
    fab_if.frame_last  = 1'b0;
    fab_if.frame_abort = 1'b0;
    fab_if.frame_data  = '0;
    fab_if.frame_bytes = 5'd0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      cycle();
      n++;
    end
    chk("drain_complete", 64'(exp_q.size()), 64'd0);
    repeat (4) cycle();
  endtask

  // Lane monitor: compare accepted lanes and check hold during stalls.
  always @(negedge clk) begin
    mon_cur = {tx_if.tx_last, tx_if.tx_bytes, tx_if.tx_data};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'({tx_if.tx_valid, mon_cur}), 64'({1'b1, held}));
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        lanes_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_lane_valid", 64'(tx_if.tx_valid), 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("lane_data", 64'(mon_cur[31:0]), 64'(mon_exp[31:0]));
          chk("lane_bytes", 64'(mon_cur[34:32]), 64'(mon_exp[34:32]));
          chk("lane_last", 64'(mon_cur[35]), 64'(mon_exp[35]));
          if (mon_exp[35]) begin
            frames_seen++;
            $display("frame %0d transmitted, frame_count=%0d drop_count=%0d",
                     frames_seen, frame_count, drop_count);
          end
        end
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      held       = mon_cur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, lat;
    bit fwd_seen;
    fab_if.frame_valid = 1'b0;
    fab_if.frame_last  = 1'b0;
    fab_if.frame_abort = 1'b0;
    fab_if.frame_bytes = 5'd0;
    fab_if.frame_data  = '0;
    tx_if.tx_ready     = 1'b0;
    rst_n              = 1'b0;
    repeat (3) cycle();

    // Reset state
    chk("rst_tx_valid", 64'(tx_if.tx_valid), 64'd0);
    chk("rst_tx_data", 64'(tx_if.tx_data), 64'd0);
    chk("rst_tx_bytes", 64'(tx_if.tx_bytes), 64'd0);
    chk("rst_tx_last", 64'(tx_if.tx_last), 64'd0);
    chk("rst_forward_en", 64'(fab_if.forward_en), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    cycle();
    chk("forward_en_after_reset", 64'(fab_if.forward_en), 64'd1);

    // 64-byte frame, ready always high
    tx_if.tx_ready = 1'b1;
    lanes_seen = 0;
    send_frame(64, 1, -1, 1'b1);
    lat = 0;
    while (!tx_if.tx_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("first_lane_within_3", 64'(lat <= 3), 64'd1);
    drain();
    chk("lanes_64B", 64'(lanes_seen), 64'd16);
    chk("frame_count_after_64B", 64'(frame_count), 64'd1);

    // 61-byte frame: tail lanes 4,4,4,1
    lanes_seen = 0;
    send_frame(61, 2, -1, 1'b1);
    drain();
    chk("lanes_61B", 64'(lanes_seen), 64'd16);
    chk("frame_count_after_61B", 64'(frame_count), 64'd2);

    // 98-word frame is dropped, next frame intact
    send_frame(98 * 16, 3, -1, 1'b0);
    repeat (10) cycle();
    chk("drop_count_oversize", 64'(drop_count), 64'd1);
    chk("frame_count_oversize", 64'(frame_count), 64'd2);
    chk("forward_en_after_oversize", 64'(fab_if.forward_en), 64'd1);
    send_frame(64, 4, -1, 1'b1);
    drain();
    chk("frame_count_after_oversize", 64'(frame_count), 64'd3);

    // Abort on word 3 of a 10-word frame
    send_frame(160, 5, 2, 1'b0);
    repeat (5) cycle();
    chk("drop_count_abort", 64'(drop_count), 64'd2);
    chk("forward_en_after_abort", 64'(fab_if.forward_en), 64'd1);
    send_frame(64, 6, -1, 1'b1);
    drain();
    chk("frame_count_after_abort", 64'(frame_count), 64'd4);

    // Fill with ready low: 40 frames of 4 words leave free=96 < 97
    tx_if.tx_ready = 1'b0;
    n = 0;
    while (fab_if.forward_en && n < 60) begin
      send_frame(64, 10 + n, -1, 1'b1);
      n++;
    end
    chk("fill_frames_accepted", 64'(n), 64'd40);
    repeat (5) cycle();
    chk("forward_en_low_when_full", 64'(fab_if.forward_en), 64'd0);

    // Random backpressure drain
    fwd_seen = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      tx_if.tx_ready = 1'($urandom_range(0, 1));
      cycle();
      if (fab_if.forward_en) fwd_seen = 1'b1;
      n++;
    end
    chk("random_drain_complete", 64'(exp_q.size()), 64'd0);
    chk("forward_en_reasserts", 64'(fwd_seen), 64'd1);
    tx_if.tx_ready = 1'b1;
    repeat (4) cycle();
    chk("frame_count_after_fill", 64'(frame_count), 64'd44);

    // Reset in the middle of transmission
    send_frame(64, 60, -1, 1'b1);
    n = 0;
    while (!tx_if.tx_valid && n < 20) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_tx_valid", 64'(tx_if.tx_valid), 64'd0);
    chk("midrst_tx_data", 64'(tx_if.tx_data), 64'd0);
    chk("midrst_tx_bytes", 64'(tx_if.tx_bytes), 64'd0);
    chk("midrst_tx_last", 64'(tx_if.tx_last), 64'd0);
    chk("midrst_forward_en", 64'(fab_if.forward_en), 64'd0);
    chk("midrst_frame_count", 64'(frame_count), 64'd0);
    cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    chk("forward_en_after_midrst", 64'(fab_if.forward_en), 64'd1);
    lanes_seen = 0;
    repeat (30) cycle();
    chk("no_stale_lanes", 64'(lanes_seen), 64'd0);
    chk("frame_count_post_reset", 64'(frame_count), 64'd0);
    send_frame(61, 61, -1, 1'b1);
    drain();
    chk("frame_count_post_reset_frame", 64'(frame_count), 64'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
